// File: rtl/mmio_acquire_arbiter.sv
// mmio_acquire_arbiter
// Shares the MMIO manager's inner TileLink port between two uncached clients
// (client 0 = core data port, client 1 = debug/system-bus port).
// The acquire channel is arbitrated round-robin (or fixed priority) and is
// locked to one client for the whole of a multibeat put-block burst.
// Grants are steered back by m_gnt_client_id; finishes are merged with
// client 0 taking priority.
// Optional build macro MMIO_ARB_STATS_EN adds per-client acquire counters and
// a counter of cycles the lock owner spent stalled mid-burst.
// Acquire bundle layout (109 bits, MSB..LSB): [108:83] block address and
// transaction id, [82:80] addr_beat, [79] is_builtin_type, [78:76] a_type,
// [75:64] union, [63:0] data.

module mmio_acquire_arbiter #(
  parameter logic [2:0] LAST_BEAT     = 3'd7,
  parameter bit         RR_EN_DEFAULT = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         c0_acq_valid,
  output logic         c0_acq_ready,
  input  logic [108:0] c0_acq_bits,
  input  logic         c1_acq_valid,
  output logic         c1_acq_ready,
  input  logic [108:0] c1_acq_bits,
  output logic         c0_gnt_valid,
  input  logic         c0_gnt_ready,
  output logic         c1_gnt_valid,
  input  logic         c1_gnt_ready,
  output logic [74:0]  gnt_bits,
  input  logic         c0_fin_valid,
  output logic         c0_fin_ready,
  input  logic [1:0]   c0_fin_id,
  input  logic         c1_fin_valid,
  output logic         c1_fin_ready,
  input  logic [1:0]   c1_fin_id,
  output logic         m_acq_valid,
  input  logic         m_acq_ready,
  output logic [108:0] m_acq_bits,
  output logic         m_acq_client_id,
  input  logic         m_gnt_valid,
  output logic         m_gnt_ready,
  input  logic [74:0]  m_gnt_bits,
  input  logic         m_gnt_client_id,
  output logic         m_fin_valid,
  input  logic         m_fin_ready,
  output logic [1:0]   m_fin_id
`ifdef MMIO_ARB_STATS_EN
  ,
  output logic [15:0]  c0_acq_count,
  output logic [15:0]  c1_acq_count,
  output logic [15:0]  lock_cycles
`endif
);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t       r_state;
  logic         r_owner;
  logic         r_rr_last;

  logic         w_sel;
  logic         w_sel_valid;
  logic [108:0] w_sel_bits;
  logic         w_fire;
  logic         w_mb;
  logic [2:0]   w_beat;
  logic         w_fin_sel;

  // Pick which client drives the acquire channel this cycle.
  always_comb begin
    w_sel = 1'b0;
    case (r_state)
      ST_LOCKED: w_sel = r_owner;
      ST_IDLE: begin
        if (c0_acq_valid && c1_acq_valid) begin
          if (RR_EN_DEFAULT) begin
            w_sel = ~r_rr_last;
          end else begin
            w_sel = 1'b0;
          end
        end else if (c1_acq_valid) begin
          w_sel = 1'b1;
        end else begin
          w_sel = 1'b0;
        end
      end
      default: w_sel = 1'b0;
    endcase
  end

  assign w_sel_valid     = w_sel ? c1_acq_valid : c0_acq_valid;
  assign w_sel_bits      = w_sel ? c1_acq_bits  : c0_acq_bits;
  assign w_fire          = w_sel_valid && m_acq_ready;
  assign w_beat          = w_sel_bits[82:80];
  assign w_mb            = w_sel_bits[79] && (w_sel_bits[78:76] == 3'd3);

  assign m_acq_valid     = w_sel_valid;
  assign m_acq_bits      = w_sel_bits;
  assign m_acq_client_id = w_sel;
  assign c0_acq_ready    = ~w_sel & m_acq_ready;
  assign c1_acq_ready    =  w_sel & m_acq_ready;

  // Lock state, lock owner and round-robin history, updated on acquire fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_owner   <= 1'b0;
      r_rr_last <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            r_rr_last <= w_sel;
            if (w_mb && (w_beat == 3'd0)) begin
              r_state <= ST_LOCKED;
              r_owner <= w_sel;
            end
          end
        end
        ST_LOCKED: begin
          if (w_fire && (w_beat == LAST_BEAT)) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Grant steering: no buffering, the destination client's ready is returned.
  assign c0_gnt_valid = m_gnt_valid & ~m_gnt_client_id;
  assign c1_gnt_valid = m_gnt_valid &  m_gnt_client_id;
  assign m_gnt_ready  = m_gnt_client_id ? c1_gnt_ready : c0_gnt_ready;
  assign gnt_bits     = m_gnt_bits;

  // Finish merge: client 1 is chosen only when client 0 has nothing to send.
  assign w_fin_sel    = ~c0_fin_valid & c1_fin_valid;
  assign m_fin_valid  = c0_fin_valid | c1_fin_valid;
  assign m_fin_id     = w_fin_sel ? c1_fin_id : c0_fin_id;
  assign c0_fin_ready = ~w_fin_sel & m_fin_ready;
  assign c1_fin_ready =  w_fin_sel & m_fin_ready;

`ifdef MMIO_ARB_STATS_EN
  logic [15:0] r_c0_cnt;
  logic [15:0] r_c1_cnt;
  logic [15:0] r_lock_cyc;
  logic        w_owner_valid;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_owner_valid = r_owner ? c1_acq_valid : c0_acq_valid;

  // Saturating activity counters: fires per client and stalled lock cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_c0_cnt   <= 16'd0;
      r_c1_cnt   <= 16'd0;
      r_lock_cyc <= 16'd0;
    end else begin
      if (w_fire && !w_sel) r_c0_cnt <= sat_inc(r_c0_cnt);
      if (w_fire &&  w_sel) r_c1_cnt <= sat_inc(r_c1_cnt);
      if ((r_state == ST_LOCKED) && !w_owner_valid) r_lock_cyc <= sat_inc(r_lock_cyc);
    end
  end

  assign c0_acq_count = r_c0_cnt;
  assign c1_acq_count = r_c1_cnt;
  assign lock_cycles  = r_lock_cyc;
`endif

endmodule
